alu_share_sched: RTL and testbench

//   Shares one ALU datapath (operand registers built from ms_flipflop cells plus

---
 rtl/alu_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 42 ++++
 rtl/alu_share_sched.sv | 158 +++++++++++++++
 tb/tb_alu_share_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Package: alu_pkg
//
// Shared definitions for the ALU sharing scheduler and the logic around it:
//   state_e   - scheduler FSM states (IDLE -> LOAD -> EXEC -> RESP)
//   alu_op_e  - opcode values understood by the shared ALU core
//   CNT_W     - width of the execute-time counter (holds 1..15)
package alu_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_PASSA = 3'd5,
    OP_PASSB = 3'd6,
    OP_NOP   = 3'd7
  } alu_op_e;

endpackage

// File: rtl/rr_arb2.sv
// Module: rr_arb2
//
// Two-way round-robin arbiter. When both requesters are valid the one that
// did not win last time is granted; a lone valid requester always wins.
// The fairness pointer only moves when the grant is actually taken.
//
// Ports:
//   eclk    in   clock
//   rst     in   asynchronous active-low reset (last_grant -> 1, so 0 wins first)
//   valid0  in   requester 0 wants the resource
//   valid1  in   requester 1 wants the resource
//   accept  in   the current grant is consumed this cycle
//   grant0  out  requester 0 would be granted
//   grant1  out  requester 1 would be granted
module rr_arb2 (
  input  logic eclk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic grant0,
  output logic grant1
);

  logic last_grant;

  // last_grant == 1 means requester 1 won most recently, so 0 has priority.
  always_comb begin
    grant0 = valid0 && (!valid1 || last_grant);
    grant1 = valid1 && (!valid0 || !last_grant);
  end

  // Remember who won; only updated when the winner is really accepted.
  always_ff @(posedge eclk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Module: alu_share_sched
//
// Shares one ALU between two requesters. A round-robin winner is accepted in
// IDLE, its opcode/operands are latched and presented to the ALU with a
// one-cycle load strobe, the result is captured after EXEC_CYCLES and held
// as a tagged response until the consumer takes it.
//
// Ports:
//   eclk, rst                  clock, asynchronous active-low reset
//   req0_valid/ready/op/a/b    requester 0 handshake and operation
//   req1_valid/ready/op/a/b    requester 1 handshake and operation
//   alu_ld                     one-cycle load enable for ALU operand registers
//   alu_op, alu_a, alu_b       operation presented to the ALU (0 when idle)
//   alu_res, alu_cout          ALU result and carry
//   rsp_valid/ready            response handshake
//   rsp_id, rsp_data, rsp_cout owner, captured result, captured carry
//   busy                       scheduler is not idle
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OPW         = 3,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             eclk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_ld,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             busy
);

  state_e             state, state_nxt;
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               id_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   data_q;
  logic               cout_q;
  logic               grant0, grant1;
  logic               in_idle;
  logic               accept;

  // Readies are also forced low while reset is held, so nothing is offered
  // to the requesters until the block is running.
  assign in_idle    = rst && (state == ST_IDLE);
  assign accept     = in_idle && (grant0 || grant1);
  assign req0_ready = in_idle && grant0;
  assign req1_ready = in_idle && grant1;

  rr_arb2 u_arb (
    .eclk   (eclk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .accept (accept),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // State register.
  always_ff @(posedge eclk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. The ALU operands are only driven while the
  // operation is in flight so the ALU sees zeros whenever the block is idle.
  always_comb begin
    state_nxt = state;
    alu_ld    = 1'b0;
    rsp_valid = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        alu_ld    = 1'b1;
        alu_op    = op_q;
        alu_a     = a_q;
        alu_b     = b_q;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
        if (cnt == CNT_W'(1)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, execute counter and result register. The counter is
  // loaded in LOAD and the result is grabbed on its last EXEC cycle, which
  // gives exactly EXEC_CYCLES cycles between the load strobe and capture.
  always_ff @(posedge eclk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      cnt    <= '0;
      data_q <= '0;
      cout_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= grant1 ? req1_op : req0_op;
        a_q  <= grant1 ? req1_a  : req0_a;
        b_q  <= grant1 ? req1_b  : req0_b;
        id_q <= grant1;
      end
      if (state == ST_LOAD) begin
        cnt <= CNT_W'(EXEC_CYCLES);
      end else if (state == ST_EXEC) begin
        cnt <= cnt - 1'b1;
      end
      if ((state == ST_EXEC) && (cnt == CNT_W'(1))) begin
        data_q <= alu_res;
        cout_q <= alu_cout;
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_cout = cout_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Testbench: tb_alu_share_sched
//
// Drives two requesters and a consumer around alu_share_sched, with a small
// registered ALU model on the ALU side. A transaction-level reference tracks
// who should be granted, when the load strobe and response should appear
// (pure cycle arithmetic from the accept point) and what the response must
// contain, and every cycle is compared against it.
module tb_alu_share_sched;
  import alu_pkg::*;

  localparam int WIDTH       = 8;
  localparam int OPW         = 3;
  localparam int EXEC_CYCLES = 2;

  logic             eclk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]   req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             alu_ld, alu_cout;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [WIDTH-1:0] rsp_data;

  // Requester-side stimulus: a pending request is held until accepted.
  bit               pend [2];
  logic [2:0]       pop  [2];
  logic [7:0]       pa   [2];
  logic [7:0]       pb   [2];
  logic             rsp_ready_drv;

  assign req0_valid = pend[0];
  assign req0_op    = pop[0];
  assign req0_a     = pa[0];
  assign req0_b     = pb[0];
  assign req1_valid = pend[1];
  assign req1_op    = pop[1];
  assign req1_a     = pa[1];
  assign req1_b     = pb[1];
  assign rsp_ready  = rsp_ready_drv;

  always #5 eclk = ~eclk;

  alu_share_sched #(
    .WIDTH       (WIDTH),
    .OPW         (OPW),
    .EXEC_CYCLES (EXEC_CYCLES)
  ) dut (
    .eclk       (eclk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_ld     (alu_ld),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  // ALU function: {carry, result}.
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] r;
    r = 9'd0;
    case (op)
      OP_ADD:   r = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = {1'b0, a} - {1'b0, b};
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_PASSA: r = {1'b0, a};
      OP_PASSB: r = {1'b0, b};
      default:  r = 9'd0;
    endcase
    return r;
  endfunction

  // ALU environment: operand registers loaded by alu_ld, combinational core.
  logic [2:0] alu_op_r = 3'd0;
  logic [7:0] alu_a_r  = 8'd0;
  logic [7:0] alu_b_r  = 8'd0;

  always @(posedge eclk) begin
    if (alu_ld) begin
      alu_op_r <= alu_op;
      alu_a_r  <= alu_a;
      alu_b_r  <= alu_b;
    end
  end

  assign {alu_cout, alu_res} = alu_fn(alu_op_r, alu_a_r, alu_b_r);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: idle flag, fairness pointer, accept cycle, transaction.
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  int         m_acc  = 0;
  bit         m_id;
  logic [2:0] m_op;
  logic [7:0] m_a, m_b;
  logic [8:0] m_res;
  int         acc_log [$];

  // Last sampled DUT values, for test-specific checks.
  logic       obs_rdy0, obs_rdy1, obs_ld, obs_rv, obs_id, obs_cout, obs_busy;
  logic [7:0] obs_data;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic [2:0] op, input logic [7:0] a,
                               input logic [7:0] b);
    pend[id] = 1'b1;
    pop[id]  = op;
    pa[id]   = a;
    pb[id]   = b;
  endtask

  task automatic maybeIssue(input bit id);
    if (!pend[id] && ($urandom_range(0, 2) == 0))
      applyStimulus(id, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
  endtask

  // One clock: sample at the falling edge, compare to the reference, then
  // advance the reference just after the rising edge.
  task automatic stepCycle();
    bit g_valid, g, exp_rv, in_alu, done;
    @(negedge eclk);
    cyc++;
    g_valid = m_idle && (pend[0] || pend[1]);
    g       = (pend[0] && pend[1]) ? !m_last : pend[1];
    exp_rv  = !m_idle && (cyc >= m_acc + 2 + EXEC_CYCLES);
    in_alu  = !m_idle && (cyc >= m_acc + 1) && (cyc <= m_acc + 1 + EXEC_CYCLES);
    checkOutput("req0_ready", 32'(req0_ready), 32'(g_valid && !g));
    checkOutput("req1_ready", 32'(req1_ready), 32'(g_valid && g));
    checkOutput("alu_ld", 32'(alu_ld), 32'(!m_idle && (cyc == m_acc + 1)));
    checkOutput("busy", 32'(busy), 32'(!m_idle));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (in_alu) begin
      checkOutput("alu_op", 32'(alu_op), 32'(m_op));
      checkOutput("alu_a", 32'(alu_a), 32'(m_a));
      checkOutput("alu_b", 32'(alu_b), 32'(m_b));
    end else if (m_idle) begin
      checkOutput("alu_idle_zero", 32'({alu_op, alu_a, alu_b}), 32'd0);
    end
    if (exp_rv) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
      checkOutput("rsp_data", 32'(rsp_data), 32'(m_res[7:0]));
      checkOutput("rsp_cout", 32'(rsp_cout), 32'(m_res[8]));
    end
    obs_rdy0 = req0_ready;
    obs_rdy1 = req1_ready;
    obs_ld   = alu_ld;
    obs_rv   = rsp_valid;
    obs_id   = rsp_id;
    obs_data = rsp_data;
    obs_cout = rsp_cout;
    obs_busy = busy;
    if (req0_ready) acc_log.push_back(0);
    if (req1_ready) acc_log.push_back(1);
    done = exp_rv && rsp_ready_drv;
    @(posedge eclk);
    #1;
    if (g_valid) begin
      m_idle  = 1'b0;
      m_acc   = cyc;
      m_id    = g;
      m_last  = g;
      m_op    = pop[g];
      m_a     = pa[g];
      m_b     = pb[g];
      m_res   = alu_fn(pop[g], pa[g], pb[g]);
      pend[g] = 1'b0;
    end else if (done) begin
      m_idle = 1'b1;
    end
  endtask

  // Hold reset for n cycles checking every output is zero, then release.
  task automatic resetDut(input int n);
    rst = 1'b0;
    repeat (n) begin
      @(negedge eclk);
      cyc++;
      checkOutput("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      checkOutput("rst_alu", 32'({alu_ld, alu_op, alu_a, alu_b}), 32'd0);
      checkOutput("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_cout}), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(posedge eclk);
      #1;
    end
    rst    = 1'b1;
    m_idle = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic drainAll(input int budget);
    while ((!m_idle || pend[0] || pend[1]) && (budget > 0)) begin
      stepCycle();
      budget--;
    end
  endtask

  task automatic waitRsp(input int budget, output bit seen, output logic [7:0] d,
                         output logic c, output logic id);
    seen = 1'b0;
    d    = 8'd0;
    c    = 1'b0;
    id   = 1'b0;
    while (!seen && (budget > 0)) begin
      stepCycle();
      budget--;
      if (obs_rv) begin
        seen = 1'b1;
        d    = obs_data;
        c    = obs_cout;
        id   = obs_id;
      end
    end
  endtask

  initial begin
    bit         seen;
    logic [7:0] d;
    logic       c, id;
    int         t_acc, t_ld, t_rv, rv_count;

    pend[0] = 1'b0; pend[1] = 1'b0;
    pop[0]  = 3'd0; pop[1]  = 3'd0;
    pa[0]   = 8'd0; pa[1]   = 8'd0;
    pb[0]   = 8'd0; pb[1]   = 8'd0;
    rsp_ready_drv = 1'b1;
    rst = 1'b1;
    #1;

    $display("[TB] reset with both requesters valid");
    applyStimulus(1'b0, OP_ADD, 8'h05, 8'h03);
    applyStimulus(1'b1, OP_SUB, 8'($urandom), 8'($urandom));
    resetDut(3);
    acc_log.delete();
    drainAll(40);
    checkOutput("reset_first_grant", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hdead, 32'd0);

    $display("[TB] single ADD latency");
    applyStimulus(1'b0, OP_ADD, 8'h05, 8'h03);
    t_acc = -1; t_ld = -1; t_rv = -1;
    for (int i = 0; (i < 20) && (t_rv < 0); i++) begin
      stepCycle();
      if (obs_rdy0 && (t_acc < 0)) t_acc = cyc;
      if (obs_ld && (t_ld < 0)) t_ld = cyc;
      if (obs_rv && (t_rv < 0)) begin
        t_rv = cyc;
        checkOutput("single_data", 32'(obs_data), 32'h08);
        checkOutput("single_id", 32'(obs_id), 32'd0);
      end
    end
    checkOutput("single_ld_latency", 32'(t_ld - t_acc), 32'd1);
    checkOutput("single_rsp_latency", 32'(t_rv - t_acc), 32'd4);
    drainAll(20);

    $display("[TB] contention");
    acc_log.delete();
    applyStimulus(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    applyStimulus(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    repeat (60) begin
      stepCycle();
      if (!pend[0]) applyStimulus(1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      if (!pend[1]) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    checkOutput("contention_count", 32'(acc_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      checkOutput("contention_order", (k < acc_log.size()) ? 32'(acc_log[k]) : 32'hdead,
                  (k % 2 == 0) ? 32'd1 : 32'd0);
    drainAll(40);

    $display("[TB] response backpressure");
    rsp_ready_drv = 1'b0;
    applyStimulus(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    waitRsp(20, seen, d, c, id);
    checkOutput("bp_rsp_seen", 32'(seen), 32'd1);
    applyStimulus(1'b0, OP_XOR, 8'($urandom), 8'($urandom));
    repeat (5) begin
      stepCycle();
      checkOutput("bp_hold", 32'(obs_rv), 32'd1);
      checkOutput("bp_stable", 32'({obs_id, obs_cout, obs_data}), 32'({id, c, d}));
      checkOutput("bp_req_ready", 32'({obs_rdy0, obs_rdy1}), 32'd0);
    end
    rsp_ready_drv = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("bp_release_idle", 32'(obs_busy), 32'd0);
    drainAll(20);

    $display("[TB] carry out");
    applyStimulus(1'b0, OP_ADD, 8'hFF, 8'h01);
    waitRsp(20, seen, d, c, id);
    checkOutput("carry_seen", 32'(seen), 32'd1);
    checkOutput("carry_data", 32'(d), 32'h00);
    checkOutput("carry_cout", 32'(c), 32'd1);
    drainAll(20);

    $display("[TB] abort during execute");
    applyStimulus(1'b0, OP_ADD, 8'($urandom), 8'($urandom));
    seen = 1'b0;
    for (int i = 0; (i < 10) && !seen; i++) begin
      stepCycle();
      if (obs_rdy0) seen = 1'b1;
    end
    checkOutput("abort_accept_seen", 32'(seen), 32'd1);
    stepCycle();
    stepCycle();
    resetDut(2);
    rv_count = 0;
    repeat (10) begin
      stepCycle();
      if (obs_rv) rv_count++;
    end
    checkOutput("abort_no_rsp", 32'(rv_count), 32'd0);

    $display("[TB] random traffic");
    repeat (300) begin
      stepCycle();
      maybeIssue(1'b0);
      maybeIssue(1'b1);
      rsp_ready_drv = ($urandom_range(0, 3) != 0);
    end
    rsp_ready_drv = 1'b1;
    drainAll(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
